// File: rtl/edge_delay_defs.sv
// Shared encodings for the edge delay buffer: edge-select modes and channel states.
package edge_delay_defs;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_FALL = 2'b01,
    MODE_RISE = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // True when the edge direction (rising = new input level) is delayed in mode m.
  function automatic logic edge_selected(input mode_e m, input logic rising);
    case (m)
      MODE_BOTH: edge_selected = 1'b1;
      MODE_RISE: edge_selected = rising;
      MODE_FALL: edge_selected = ~rising;
      default:   edge_selected = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_delay_channel.sv
// One channel of the edge delay buffer: inertial delay of selected edges by a
// programmable cycle count captured when the delay starts.
module edge_delay_channel
  import edge_delay_defs::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         x,
  input  logic [W-1:0] dly,
  input  logic [1:0]   mode,
  output logic         z,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         z_q, z_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    case (state_q)
      ST_SYNC: begin
        if (x != z_q) begin
          // Edge arrives already counting: dly-1 so z updates exactly dly edges later.
          if (edge_selected(mode_e'(mode), x) && (dly != '0)) begin
            cnt_d   = dly - W'(1);
            state_d = ST_WAIT;
          end else begin
            z_d = x;
          end
        end
      end
      ST_WAIT: begin
        if (x == z_q) begin
          state_d = ST_SYNC;
        end else if (cnt_q == '0) begin
          z_d     = x;
          state_d = ST_SYNC;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign z    = z_q;
  assign busy = (state_q == ST_WAIT);

endmodule

// File: rtl/edge_delay_buffer.sv
// N-channel clocked edge delay buffer; shared delay and mode fan out to
// independent per-channel delay FSMs.
module edge_delay_buffer #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [N-1:0] x,
  input  logic [W-1:0] dly,
  input  logic [1:0]   mode,
  output logic [N-1:0] z,
  output logic [N-1:0] busy
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    edge_delay_channel #(.W(W)) u_ch (
      .clock  (clock),
      .reset_ (reset_),
      .x      (x[i]),
      .dly    (dly),
      .mode   (mode),
      .z      (z[i]),
      .busy   (busy[i])
    );
  end

endmodule

// File: tb/tb_edge_delay_buffer.sv
// Directed bench for edge_delay_buffer: linear stimulus with hand-computed
// expectations, sampled 1ns after each rising clock edge.
module tb_edge_delay_buffer;

  logic       clock = 1'b0;
  logic       reset_;
  logic [3:0] x;
  logic [3:0] dly;
  logic [1:0] mode;
  logic [3:0] z;
  logic [3:0] busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  edge_delay_buffer #(.N(4), .W(4)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .x      (x),
    .dly    (dly),
    .mode   (mode),
    .z      (z),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset_ = 1'b0;
    x      = 4'b1111;
    mode   = 2'b00;
    dly    = 4'd0;

    // Reset held with inputs high
    tick(); tick(); tick();
    chk("rst_z", z, 4'b0000);
    chk("rst_busy", busy, 4'b0000);
    reset_ = 1'b1;
    tick();
    chk("rel_z", z, 4'b1111);
    chk("rel_busy", busy, 4'b0000);

    // FALL mode, dly=5: x0 falls (delayed), x1 rises (passes)
    x = 4'b0001;
    tick();
    chk("setup_fall_z", z, 4'b0001);
    mode = 2'b01; dly = 4'd5; x = 4'b0010;
    tick();
    chk("fall_k_z", z, 4'b0011);
    chk("fall_k_busy", busy, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("fall_wait_z", z, 4'b0011);
      chk("fall_wait_busy", busy, 4'b0001);
    end
    tick();
    chk("fall_k5_z", z, 4'b0010);
    chk("fall_k5_busy", busy, 4'b0000);

    // BOTH mode, dly=3: 2-cycle pulse on x2 is absorbed
    mode = 2'b11; dly = 4'd3; x = 4'b0110;
    tick();
    chk("glitch_k_busy", busy, 4'b0100);
    tick();
    chk("glitch_k1_z", z, 4'b0010);
    x = 4'b0010;
    tick();
    chk("glitch_end_busy", busy, 4'b0000);
    chk("glitch_end_z", z, 4'b0010);
    tick(); tick();
    chk("glitch_after_z", z, 4'b0010);

    // BOTH mode, dly=3: 4-cycle pulse shifted by 3, width preserved
    x = 4'b0110;
    tick();
    chk("pulse_k_z", z, 4'b0010);
    chk("pulse_k_busy", busy, 4'b0100);
    tick(); tick();
    chk("pulse_k2_z", z, 4'b0010);
    tick();
    chk("pulse_rise_z", z, 4'b0110);
    chk("pulse_rise_busy", busy, 4'b0000);
    x = 4'b0010;
    tick();
    chk("pulse_k4_z", z, 4'b0110);
    chk("pulse_k4_busy", busy, 4'b0100);
    tick(); tick();
    chk("pulse_k6_z", z, 4'b0110);
    tick();
    chk("pulse_fall_z", z, 4'b0010);
    chk("pulse_fall_busy", busy, 4'b0000);

    // Mode/dly changed mid-wait do not affect pending fall on x3
    mode = 2'b00; x = 4'b1010;
    tick();
    chk("setup_x3_z", z, 4'b1010);
    mode = 2'b01; dly = 4'd7; x = 4'b0010;
    tick();
    chk("cap_k_busy", busy, 4'b1000);
    tick();
    mode = 2'b00; dly = 4'd1;
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk("cap_wait_z", z, 4'b1010);
      chk("cap_wait_busy", busy, 4'b1000);
    end
    tick();
    chk("cap_k7_z", z, 4'b0010);
    chk("cap_k7_busy", busy, 4'b0000);

    // dly=0: every edge passes after edge k
    mode = 2'b11; dly = 4'd0; x = 4'b1101;
    tick();
    chk("d0_both_z", z, 4'b1101);
    chk("d0_both_busy", busy, 4'b0000);
    x = 4'b0010;
    tick();
    chk("d0_both2_z", z, 4'b0010);
    mode = 2'b10; x = 4'b1111;
    tick();
    chk("d0_rise_z", z, 4'b1111);

    // dly=15: maximum delay without counter wrap
    mode = 2'b01; dly = 4'd15; x = 4'b1110;
    tick();
    chk("d15_k_busy", busy, 4'b0001);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("d15_wait_z", z, 4'b1111);
    end
    chk("d15_k14_busy", busy, 4'b0001);
    tick();
    chk("d15_k15_z", z, 4'b1110);
    chk("d15_k15_busy", busy, 4'b0000);

    // Reset mid-wait drops the pending edge
    dly = 4'd5; x = 4'b1100;
    tick();
    chk("rw_k_busy", busy, 4'b0010);
    tick();
    reset_ = 1'b0;
    tick();
    chk("rw_rst_z", z, 4'b0000);
    chk("rw_rst_busy", busy, 4'b0000);
    reset_ = 1'b1; x = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rw_after_z", z, 4'b0000);
      chk("rw_after_busy", busy, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
